// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word, fetch state, fetch buffer entry
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        FULL,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
    } fetch_entry_t;

    localparam int FETCH_DEPTH = 2;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO of fetched words; flush beats push and pop
module fetch_buffer
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [PW-1:0]  r_rd;
    logic [PW-1:0]  r_wr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || pop);
    assign w_do_pop  = pop && (r_count != '0);

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= ptr_inc(r_wr);
            if (w_do_pop)  r_rd <= ptr_inc(r_rd);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push && !flush) r_mem[r_wr] <= din;
    end

    assign head  = r_mem[r_rd];
    assign count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and 2-deep instruction prefetcher feeding decode
// Optional perf counters (fetch_cnt, stall_cnt) when IFETCH_PERF_EN is defined.
module instr_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter int    DEPTH   = FETCH_DEPTH
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
`ifdef IFETCH_PERF_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        halted
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    word_t         r_pc;
    word_t         w_pc_next;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_consume;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    fetch_entry_t  w_head;
    fetch_entry_t  w_din;

    fetch_buffer #(.DEPTH(DEPTH), .CW(CW)) u_buf (
        .CLK   (CLK),
        .RST   (RST),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_din),
        .head  (w_head),
        .count (w_count)
    );

    assign w_consume   = instr_valid && instr_ready;
    assign w_din       = '{instr: iload, npc: r_pc + 32'd4};
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    // Halt beats redirect, redirect beats any fetch or consume in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        if (r_state == HALTED) begin
            w_flush = 1'b1;
        end else if (w_consume && halt) begin
            w_flush      = 1'b1;
            w_state_next = HALTED;
        end else if (redirect) begin
            w_flush      = 1'b1;
            w_pc_next    = redirect_pc & ~32'h3;
            w_state_next = FETCH;
        end else begin
            w_push = ihit && (r_state == FETCH);
            w_pop  = w_consume;
            if (w_push) w_pc_next = r_pc + 32'd4;
            w_state_next = (w_count_next == CW'(DEPTH)) ? FULL : FETCH;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= FETCH;
            r_pc    <= PC_INIT & ~32'h3;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    assign iREN        = (r_state == FETCH) && !RST;
    assign iaddr       = r_pc;
    assign instr_valid = (w_count != '0);
    assign instr       = instr_valid ? w_head.instr : 32'h0;
    assign npc         = instr_valid ? w_head.npc : 32'h0;
    assign halted      = (r_state == HALTED);

`ifdef IFETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (r_state != HALTED) begin
            if (w_consume)     r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (iREN && !ihit) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] iload = '0;
    logic        instr_ready = 1'b0;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        iREN, instr_valid, halted;
    logic [31:0] iaddr, instr, npc;
    logic        w1_iren, w1_valid, w1_halted;
    logic [31:0] w1_iaddr, w1_instr, w1_npc;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt, w1_fetch_cnt, w1_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    instr_fetch_unit u0 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
        .instr(instr), .npc(npc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef IFETCH_PERF_EN
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
        .halted(halted)
    );

    instr_fetch_unit #(.PC_INIT(32'hFFFF_FFF8)) u1 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(w1_iren), .iaddr(w1_iaddr),
        .instr(w1_instr), .npc(w1_npc), .instr_valid(w1_valid), .instr_ready(instr_ready),
        .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef IFETCH_PERF_EN
        .fetch_cnt(w1_fetch_cnt), .stall_cnt(w1_stall_cnt),
`endif
        .halted(w1_halted)
    );

    typedef struct {
        logic        rst, hit;
        logic [31:0] load;
        logic        rdy, hlt, rdr;
        logic [31:0] rpc;
        logic        e_iren;
        logic [31:0] e_iaddr;
        logic        e_valid;
        logic [31:0] e_instr, e_npc;
        logic        e_halted;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    logic [63:0] sbq [$];
    int          cnt;
    logic [31:0] exp_pc;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(logic rst, logic hit, logic [31:0] load, logic rdy, logic hlt,
                                 logic rdr, logic [31:0] rpc, logic e_iren, logic [31:0] e_iaddr,
                                 logic e_valid, logic [31:0] e_instr, logic [31:0] e_npc,
                                 logic e_halted);
        vec_t v;
        v.rst = rst; v.hit = hit; v.load = load; v.rdy = rdy; v.hlt = hlt; v.rdr = rdr;
        v.rpc = rpc; v.e_iren = e_iren; v.e_iaddr = e_iaddr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_npc = e_npc; v.e_halted = e_halted;
        return v;
    endfunction

    task automatic drive(input logic r, input logic h, input logic [31:0] d, input logic rd,
                         input logic hl, input logic rdr, input logic [31:0] rpc);
        RST = r; ihit = h; iload = d; instr_ready = rd; halt = hl;
        redirect = rdr; redirect_pc = rpc;
    endtask

    // Bench-side reference: expected occupancy, PC and queued {instr, npc} pairs.
    task automatic sb_cycle(input logic h, input logic rd, input logic [31:0] d);
        int c0;
        c0 = cnt;
        chk1("sb_valid", instr_valid, c0 > 0);
        chk1("sb_iren", iREN, c0 < 2);
        chk("sb_iaddr", iaddr, exp_pc);
        if (c0 > 0) begin
            chk("sb_instr", instr, sbq[0][63:32]);
            chk("sb_npc", npc, sbq[0][31:0]);
        end
        drive(1'b0, h, d, rd, 1'b0, 1'b0, 32'h0);
        if (rd && c0 > 0) begin
            void'(sbq.pop_front());
            cnt--;
        end
        if (h && c0 < 2) begin
            sbq.push_back({d, exp_pc + 32'd4});
            exp_pc = exp_pc + 32'd4;
            cnt++;
        end
        tick();
    endtask

    initial begin
        //            rst hit load          rdy hlt rdr rpc            iren iaddr        v  instr         npc           hd
        vecs[0]  = mkv(1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0,        0);
        vecs[1]  = mkv(0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h0,        0, 32'h0,        32'h0,        0);
        vecs[2]  = mkv(0, 1, 32'h2001_0005,  1, 0, 0, 32'h0,          1, 32'h4,        1, 32'h2001_0005, 32'h4,       0);
        vecs[3]  = mkv(0, 1, 32'h2002_0007,  1, 0, 0, 32'h0,          1, 32'h8,        1, 32'h2002_0007, 32'h8,       0);
        vecs[4]  = mkv(0, 1, 32'h0000_0033,  0, 0, 0, 32'h0,          0, 32'hC,        1, 32'h2002_0007, 32'h8,       0);
        vecs[5]  = mkv(0, 0, 32'h0,          0, 0, 0, 32'h0,          0, 32'hC,        1, 32'h2002_0007, 32'h8,       0);
        vecs[6]  = mkv(0, 1, 32'hDEAD_BEEF,  0, 0, 0, 32'h0,          0, 32'hC,        1, 32'h2002_0007, 32'h8,       0);
        vecs[7]  = mkv(0, 0, 32'h0,          1, 0, 0, 32'h0,          1, 32'hC,        1, 32'h0000_0033, 32'hC,       0);
        vecs[8]  = mkv(0, 1, 32'hBAD0_0001,  0, 0, 1, 32'h0000_0103,  1, 32'h100,      0, 32'h0,        32'h0,        0);
        vecs[9]  = mkv(0, 1, 32'hFFFF_FFFF,  0, 0, 0, 32'h0,          1, 32'h104,      1, 32'hFFFF_FFFF, 32'h104,     0);
        vecs[10] = mkv(0, 0, 32'h0,          0, 1, 0, 32'h0,          1, 32'h104,      1, 32'hFFFF_FFFF, 32'h104,     0);
        vecs[11] = mkv(0, 1, 32'h1234_5678,  1, 1, 1, 32'h0000_0200,  0, 32'h104,      0, 32'h0,        32'h0,        1);
        vecs[12] = mkv(0, 1, 32'h1111_2222,  1, 0, 1, 32'h0000_0300,  0, 32'h104,      0, 32'h0,        32'h0,        1);
        vecs[13] = mkv(1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0,        0);
        vecs[14] = mkv(0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h0,        0, 32'h0,        32'h0,        0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].hit, vecs[i].load, vecs[i].rdy, vecs[i].hlt,
                  vecs[i].rdr, vecs[i].rpc);
            tick();
            chk1($sformatf("v%0d_iren", i), iREN, vecs[i].e_iren);
            chk($sformatf("v%0d_iaddr", i), iaddr, vecs[i].e_iaddr);
            chk1($sformatf("v%0d_valid", i), instr_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
            chk($sformatf("v%0d_npc", i), npc, vecs[i].e_npc);
            chk1($sformatf("v%0d_halted", i), halted, vecs[i].e_halted);
        end

        // Scoreboard run: fill to two, then full-rate stream, then random traffic.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        cnt = 0;
        exp_pc = 32'h0;
        sbq.delete();
        for (int i = 0; i < 3; i++) sb_cycle(1'b1, 1'b0, 32'hA000_0000 + i);
        for (int i = 0; i < 10; i++) sb_cycle(1'b1, 1'b1, 32'hB000_0000 + i);
        for (int i = 0; i < 150; i++)
            sb_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

        // PC wrap on the second instance.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_iaddr0", w1_iaddr, 32'hFFFF_FFF8);
        drive(1'b0, 1'b1, 32'h0000_0A0A, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_iaddr1", w1_iaddr, 32'hFFFF_FFFC);
        chk("wrap_npc1", w1_npc, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 32'h0000_0B0B, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_iaddr2", w1_iaddr, 32'h0);
        chk1("wrap_full_iren", w1_iren, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_instr2", w1_instr, 32'h0000_0B0B);
        chk("wrap_npc2", w1_npc, 32'h0);

`ifdef IFETCH_PERF_EN
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("perf_fetch", fetch_cnt, 32'd3);
        chk("perf_stall", stall_cnt, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
